// File: rtl/ctrl_pkg.sv
// Shared types and helpers for the multi-cycle control FSM.
// The IRQ state exists only when CTRL_IRQ_EN is defined.
package ctrl_pkg;

`ifdef CTRL_IRQ_EN
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EX_ALU, S_EX_JMP, S_EX_BZ,
        S_MEM_RD, S_MEM_WR, S_HALTED, S_FAULT, S_IRQ
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EX_ALU, S_EX_JMP, S_EX_BZ,
        S_MEM_RD, S_MEM_WR, S_HALTED, S_FAULT
    } state_t;
`endif

    // Non-ALU opcodes sit directly above the ALU range; halt is all-ones.
    function automatic int opc_jmp(input int alu_ops);
        return alu_ops;
    endfunction

    function automatic int opc_bz(input int alu_ops);
        return alu_ops + 1;
    endfunction

    function automatic int opc_ld(input int alu_ops);
        return alu_ops + 2;
    endfunction

    function automatic int opc_st(input int alu_ops);
        return alu_ops + 3;
    endfunction

    function automatic int opc_hlt(input int op_w);
        return (1 << op_w) - 1;
    endfunction

    function automatic int wait_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; expired flags the last
// permitted wait cycle so the FSM can leave for FAULT.
module mem_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    input  logic ready,
    output logic expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (start)
            cnt <= '0;
        else if (busy && !ready)
            cnt <= cnt + 1'b1;
    end

    // Fires when this cycle's increment would make the count reach TIMEOUT;
    // a ready in the same cycle masks it.
    assign expired = busy && !ready && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXECUTE control FSM for the 16-bit core.
// Optional interrupt entry (irq/irq_ack, IRQ state) under CTRL_IRQ_EN.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int ALU_OPS = 8,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    input  logic            resume,
`ifdef CTRL_IRQ_EN
    input  logic            irq,
    output logic            irq_ack,
`endif
    output logic            ir_load,
    output logic            rd,
    output logic            wr,
    output logic            inc_pc,
    output logic            load_pc,
    output logic            alu,
    output logic [OP_W-1:0] alu_op,
    output logic            reg_we,
    output logic            halt,
    output logic            fault
);

    localparam int            CW      = wait_cnt_w(TIMEOUT);
    localparam logic [OP_W:0] ALU_LIM = (OP_W + 1)'(ALU_OPS);
    localparam logic [OP_W-1:0] OPC_JMP = OP_W'(opc_jmp(ALU_OPS));
    localparam logic [OP_W-1:0] OPC_BZ  = OP_W'(opc_bz(ALU_OPS));
    localparam logic [OP_W-1:0] OPC_LD  = OP_W'(opc_ld(ALU_OPS));
    localparam logic [OP_W-1:0] OPC_ST  = OP_W'(opc_st(ALU_OPS));
    localparam logic [OP_W-1:0] OPC_HLT = OP_W'(opc_hlt(OP_W));

    state_t state, nxt;
    logic   go_fetch;
    logic   wait_busy, wait_start, expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            alu_op <= '0;
        else if (state == S_DECODE)
            alu_op <= op;
    end

    always_comb begin
        nxt      = state;
        go_fetch = 1'b0;
        case (state)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    nxt = S_DECODE;
                else if (expired) nxt = S_FAULT;
            end
            S_DECODE: begin
                if ({1'b0, op} < ALU_LIM) nxt = S_EX_ALU;
                else if (op == OPC_JMP)   nxt = S_EX_JMP;
                else if (op == OPC_BZ)    nxt = S_EX_BZ;
                else if (op == OPC_LD)    nxt = S_MEM_RD;
                else if (op == OPC_ST)    nxt = S_MEM_WR;
                else if (op == OPC_HLT)   nxt = S_HALTED;
                else                      nxt = S_FAULT;
            end
            S_EX_ALU, S_EX_JMP, S_EX_BZ: go_fetch = 1'b1;
            S_MEM_RD, S_MEM_WR: begin
                if (mem_ready)    go_fetch = 1'b1;
                else if (expired) nxt = S_FAULT;
            end
`ifdef CTRL_IRQ_EN
            S_HALTED: go_fetch = resume || irq;
            S_IRQ:    nxt = S_FETCH;
`else
            S_HALTED: go_fetch = resume;
`endif
            S_FAULT:  nxt = S_FAULT;
            default:  nxt = S_IDLE;
        endcase
        if (go_fetch) nxt = S_FETCH;
`ifdef CTRL_IRQ_EN
        // Interrupts are taken only at instruction boundaries heading into FETCH.
        if (go_fetch && irq) nxt = S_IRQ;
`endif
    end

    assign wait_busy  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign wait_start = (nxt != state) &&
                        ((nxt == S_FETCH) || (nxt == S_MEM_RD) || (nxt == S_MEM_WR));

    mem_wait_timer #(.TIMEOUT(TIMEOUT), .W(CW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (wait_start),
        .busy    (wait_busy),
        .ready   (mem_ready),
        .expired (expired)
    );

    always_comb begin
        ir_load = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        alu     = 1'b0;
        reg_we  = 1'b0;
        halt    = 1'b0;
        fault   = 1'b0;
`ifdef CTRL_IRQ_EN
        irq_ack = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                rd      = 1'b1;
                ir_load = mem_ready;
                inc_pc  = mem_ready;
            end
            S_EX_ALU: begin
                alu    = 1'b1;
                reg_we = 1'b1;
            end
            S_EX_JMP: load_pc = 1'b1;
            S_EX_BZ:  load_pc = zero;
            S_MEM_RD: begin
                rd     = 1'b1;
                reg_we = mem_ready;
            end
            S_MEM_WR: wr = 1'b1;
            S_HALTED: halt = 1'b1;
            S_FAULT: begin
                halt  = 1'b1;
                fault = 1'b1;
            end
`ifdef CTRL_IRQ_EN
            S_IRQ: begin
                irq_ack = 1'b1;
                load_pc = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: stimulus pushes per-cycle expected
// outputs into a queue, a negedge monitor pops and compares.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] op = 4'd0;
    logic       zero = 1'b0, mem_ready = 1'b0, resume = 1'b0;
    logic       irq = 1'b0;
    logic       irq_ack_s;
    logic       ir_load, rd, wr, inc_pc, load_pc, alu, reg_we, halt, fault;
    logic [3:0] alu_op;

    always #5 clk = ~clk;

    multicycle_control #(.OP_W(4), .ALU_OPS(8), .TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .resume    (resume),
`ifdef CTRL_IRQ_EN
        .irq       (irq),
        .irq_ack   (irq_ack_s),
`endif
        .ir_load   (ir_load),
        .rd        (rd),
        .wr        (wr),
        .inc_pc    (inc_pc),
        .load_pc   (load_pc),
        .alu       (alu),
        .alu_op    (alu_op),
        .reg_we    (reg_we),
        .halt      (halt),
        .fault     (fault)
    );

`ifndef CTRL_IRQ_EN
    assign irq_ack_s = 1'b0;
`endif

    // Flag order: {ir_load, rd, wr, inc_pc, load_pc, alu, reg_we, halt, fault}
    localparam logic [8:0] F_Z    = 9'b000000000;
    localparam logic [8:0] F_RD   = 9'b010000000;
    localparam logic [8:0] F_FOK  = 9'b110100000;
    localparam logic [8:0] F_ALU  = 9'b000001100;
    localparam logic [8:0] F_LD   = 9'b000010000;
    localparam logic [8:0] F_RDOK = 9'b010000100;
    localparam logic [8:0] F_WR   = 9'b001000000;
    localparam logic [8:0] F_H    = 9'b000000010;
    localparam logic [8:0] F_FLT  = 9'b000000011;

    // Input bits: {reset, mem_ready, zero, resume, irq}
    localparam logic [4:0] RST = 5'b10000;
    localparam logic [4:0] M   = 5'b01000;
    localparam logic [4:0] ZR  = 5'b00100;
    localparam logic [4:0] RS  = 5'b00010;
    localparam logic [4:0] IQ  = 5'b00001;

    typedef struct {
        string      name;
        logic [8:0] f;
        logic [3:0] aop;
        logic       ack;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   npass = 0;

    task automatic cyc(input string n, input logic [4:0] in, input logic [3:0] o,
                       input logic [8:0] f, input logic [3:0] a = 4'd0,
                       input logic ack = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = in[4];
        mem_ready = in[3];
        zero      = in[2];
        resume    = in[1];
        irq       = in[0];
        op        = o;
        e.name = n;
        e.f    = f;
        e.aop  = a;
        e.ack  = ack;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [8:0] act;
            logic       ok;
            e   = q.pop_front();
            act = {ir_load, rd, wr, inc_pc, load_pc, alu, reg_we, halt, fault};
            ok  = (act == e.f) && (!e.f[3] || alu_op == e.aop);
`ifdef CTRL_IRQ_EN
            ok  = ok && (irq_ack_s == e.ack);
`endif
            nchk++;
            if (ok) npass++;
            else $display("FAIL %s: got flags=%b alu_op=%0d ack=%b, want flags=%b alu_op=%0d ack=%b",
                          e.name, act, alu_op, irq_ack_s, e.f, e.aop, e.ack);
        end
    end

    initial begin
        cyc("rst0", RST, 0, F_Z);
        cyc("rst1", RST, 0, F_Z);
        cyc("idle", 0, 0, F_Z);
        // ALU op 3 with zero wait
        cyc("alu_fetch", M, 3, F_FOK);
        cyc("alu_dec", 0, 3, F_Z);
        cyc("alu_ex", 0, 3, F_ALU, 3);
        // LD with 4 wait cycles
        cyc("ld_fwait", 0, 10, F_RD);
        cyc("ld_fetch", M, 10, F_FOK);
        cyc("ld_dec", 0, 10, F_Z);
        repeat (4) cyc("ld_wait", 0, 10, F_RD);
        cyc("ld_done", M, 10, F_RDOK);
        // BZ taken / not taken
        cyc("bz1_fetch", M, 9, F_FOK);
        cyc("bz1_dec", 0, 9, F_Z);
        cyc("bz1_ex", ZR, 9, F_LD);
        cyc("bz0_fetch", M, 9, F_FOK);
        cyc("bz0_dec", 0, 9, F_Z);
        cyc("bz0_ex", 0, 9, F_Z);
        // Highest ALU opcode, then JMP
        cyc("alu7_fetch", M, 7, F_FOK);
        cyc("alu7_dec", 0, 7, F_Z);
        cyc("alu7_ex", 0, 7, F_ALU, 7);
        cyc("jmp_fetch", M, 8, F_FOK);
        cyc("jmp_dec", 0, 8, F_Z);
        cyc("jmp_ex", 0, 8, F_LD);
        // Store with 2 wait cycles
        cyc("st_fetch", M, 11, F_FOK);
        cyc("st_dec", 0, 11, F_Z);
        repeat (2) cyc("st_wait", 0, 11, F_WR);
        cyc("st_done", M, 11, F_WR);
        // Halt, resume, then illegal opcode
        cyc("hlt_fetch", M, 15, F_FOK);
        cyc("hlt_dec", 0, 15, F_Z);
        repeat (10) cyc("hlt", 0, 15, F_H);
        cyc("hlt_res", RS, 15, F_H);
        cyc("res_fetch", 0, 15, F_RD);
        cyc("ill_fetch", M, 12, F_FOK);
        cyc("ill_dec", 0, 12, F_Z);
        cyc("ill_flt", RS, 12, F_FLT);
        cyc("ill_hold", 0, 12, F_FLT);
        cyc("flt_rst", RST, 0, F_Z);
        cyc("idle2", 0, 0, F_Z);
        // Ready on the last permitted wait cycle wins over timeout
        repeat (14) cyc("to14_wait", 0, 3, F_RD);
        cyc("to15_ready", M, 3, F_FOK);
        cyc("to15_dec", 0, 3, F_Z);
        cyc("to15_ex", 0, 3, F_ALU, 3);
        // Full timeout
        repeat (15) cyc("to_wait", 0, 3, F_RD);
        cyc("to_fault", 0, 3, F_FLT);
        cyc("to_resume", RS, 3, F_FLT);
        cyc("to_hold", M, 3, F_FLT);
        cyc("to_rst", RST, 0, F_Z);
        cyc("idle3", 0, 0, F_Z);
        // Reset mid-store drops wr at once
        cyc("wr_fetch", M, 11, F_FOK);
        cyc("wr_dec", 0, 11, F_Z);
        cyc("wr_pend", 0, 11, F_WR);
        cyc("wr_rst", RST, 11, F_Z);
        cyc("idle4", 0, 0, F_Z);
        cyc("re_fetch", M, 3, F_FOK);
        cyc("re_dec", 0, 3, F_Z);
        cyc("re_ex", 0, 3, F_ALU, 3);
`ifdef CTRL_IRQ_EN
        cyc("ih_fetch", M, 15, F_FOK);
        cyc("ih_dec", 0, 15, F_Z);
        cyc("ih_halt", IQ, 15, F_H);
        cyc("ih_irq", 0, 15, F_LD, 0, 1'b1);
        cyc("ia_fetch", M, 3, F_FOK);
        cyc("ia_dec", 0, 3, F_Z);
        cyc("ia_ex", IQ, 3, F_ALU, 3);
        cyc("ia_irq", 0, 3, F_LD, 0, 1'b1);
        cyc("ia_after", 0, 3, F_RD);
`endif
        @(posedge clk);
        @(negedge clk);
        #1;
        nchk++;
        if (q.size() == 0) npass++;
        else $display("FAIL drain: got %0d pending entries, want 0", q.size());
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
